// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-stage and memory handshake signals around mem_port_arbiter.
// slave is the arbiter's view; master is the view of the stage logic plus memory model.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ready;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the MEM stage.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ready_q,  if_ready_d;
    logic          dm_ready_q,  dm_ready_d;
    logic [DW-1:0] if_rdata_q,  if_rdata_d;
    logic [DW-1:0] dm_rdata_q,  dm_rdata_d;
    logic          busy_q,      busy_d;

    logic          if_elig_s;
    logic          dm_elig_s;
    logic          if_first_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    logic [2:0]    starve_q, starve_d;
`endif

    // Arbitration, transaction tracking and completion handling
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        // A port in its own ready cycle is still showing the old request.
        dm_elig_s = bus.dm_req & ~dm_ready_q;
        if_elig_s = bus.if_req & ~if_ready_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_d   = starve_q;
        if_first_s = if_elig_s & (starve_q == STARVE_MAX);
`else
        if_first_s = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (dm_elig_s && !if_first_s) begin
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
`ifdef MEM_ARB_STARVE_GUARD_EN
                    if (!bus.if_req) begin
                        starve_d = 3'd0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 3'd1;
                    end else begin
                        starve_d = starve_q;
                    end
`endif
                end else if (if_elig_s) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = {DW{1'b0}};
`ifdef MEM_ARB_STARVE_GUARD_EN
                    starve_d    = 3'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            DM_BUSY: begin
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = bus.mem_rdata;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    state_d = DM_BUSY;
                end
            end

            IF_BUSY: begin
                if (bus.mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end else begin
                    state_d = IF_BUSY;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= {DW{1'b0}};
            dm_rdata_q  <= {DW{1'b0}};
            busy_q      <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_q    <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then randomized traffic
// against a transaction-level reference model of the two requesters and the memory.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one outstanding access record plus the per-port results.
    logic        m_valid;
    logic        m_is_dm;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_if_rdy;
    logic        m_dm_rdy;
    logic [31:0] m_if_rd;
    logic [31:0] m_dm_rd;
    int          m_starve;

    logic [31:0] mem [16];
    logic        mem_started;
    int          wait_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at time %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic        p_rst, p_if_req, p_dm_req, p_dm_we, p_ack;
        logic [31:0] p_if_addr, p_dm_addr, p_dm_wdata, p_rdata;
        logic        dm_ok, if_ok, old_if_rdy, old_dm_rdy, pick_if;
        @(posedge clk);
        p_rst      = rst;
        p_if_req   = bus.if_req;
        p_if_addr  = bus.if_addr;
        p_dm_req   = bus.dm_req;
        p_dm_we    = bus.dm_we;
        p_dm_addr  = bus.dm_addr;
        p_dm_wdata = bus.dm_wdata;
        p_ack      = bus.mem_ack;
        p_rdata    = bus.mem_rdata;

        if (p_rst) begin
            m_valid = 1'b0; m_is_dm = 1'b0; m_we = 1'b0;
            m_addr = 32'h0; m_wdata = 32'h0;
            m_if_rdy = 1'b0; m_dm_rdy = 1'b0;
            m_if_rd = 32'h0; m_dm_rd = 32'h0;
            m_starve = 0;
        end else begin
            old_if_rdy = m_if_rdy;
            old_dm_rdy = m_dm_rdy;
            m_if_rdy = 1'b0;
            m_dm_rdy = 1'b0;
            if (m_valid) begin
                if (p_ack) begin
                    if (m_is_dm) begin
                        m_dm_rdy = 1'b1;
                        if (!m_we) m_dm_rd = p_rdata;
                    end else begin
                        m_if_rdy = 1'b1;
                        m_if_rd  = p_rdata;
                    end
                    m_valid = 1'b0;
                    m_we    = 1'b0;
                end
            end else begin
                dm_ok = p_dm_req && !old_dm_rdy;
                if_ok = p_if_req && !old_if_rdy;
`ifdef MEM_ARB_STARVE_GUARD_EN
                pick_if = if_ok && (!dm_ok || m_starve == STARVE_LIMIT);
`else
                pick_if = if_ok && !dm_ok;
`endif
                if (pick_if) begin
                    m_valid = 1'b1; m_is_dm = 1'b0; m_we = 1'b0;
                    m_addr = p_if_addr; m_wdata = 32'h0;
                    m_starve = 0;
                end else if (dm_ok) begin
                    m_valid = 1'b1; m_is_dm = 1'b1; m_we = p_dm_we;
                    m_addr = p_dm_addr; m_wdata = p_dm_wdata;
                    if (!p_if_req) m_starve = 0;
                    else if (m_starve < STARVE_LIMIT) m_starve = m_starve + 1;
                end
            end
        end

        #1;
        check("mem_req",   32'(bus.mem_req),  32'(m_valid));
        check("mem_we",    32'(bus.mem_we),   32'(m_we));
        check("mem_addr",  bus.mem_addr,      m_addr);
        check("mem_wdata", bus.mem_wdata,     m_wdata);
        check("if_ready",  32'(bus.if_ready), 32'(m_if_rdy));
        check("dm_ready",  32'(bus.dm_ready), 32'(m_dm_rdy));
        check("if_rdata",  bus.if_rdata,      m_if_rd);
        check("dm_rdata",  bus.dm_rdata,      m_dm_rd);
        check("busy",      32'(bus.busy),     32'(m_valid));
        check("one_ready", 32'(bus.if_ready & bus.dm_ready), 32'h0);
    endtask

    // Stage and memory behaviour for the randomized phase.
    task automatic drive_random();
        if (!bus.if_req || m_if_rdy) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        end else if ($urandom_range(0, 63) == 0) begin
            bus.if_req = 1'b0;
        end
        if (!bus.dm_req || m_dm_rdy) begin
            bus.dm_req   = ($urandom_range(0, 2) != 0);
            bus.dm_we    = ($urandom_range(0, 1) == 1);
            bus.dm_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            bus.dm_wdata = $urandom;
        end else if ($urandom_range(0, 63) == 0) begin
            bus.dm_req = 1'b0;
        end

        if (!m_valid) mem_started = 1'b0;
        if (m_valid && !mem_started) begin
            mem_started = 1'b1;
            wait_cnt = $urandom_range(0, 2);
        end
        if (m_valid && wait_cnt == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[m_addr[5:2]];
            if (m_we) mem[m_addr[5:2]] = m_wdata;
        end else begin
            bus.mem_ack   = !m_valid && ($urandom_range(0, 7) == 0);
            bus.mem_rdata = $urandom;
            if (m_valid) wait_cnt = wait_cnt - 1;
        end
        rst = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        m_valid = 1'b0; m_is_dm = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
        m_if_rdy = 1'b0; m_dm_rdy = 1'b0; m_if_rd = 32'h0; m_dm_rd = 32'h0; m_starve = 0;
        mem_started = 1'b0; wait_cnt = 0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        cycle();
        check("rst_busy", 32'(bus.busy), 32'h0);
        cycle();
        rst = 1'b0;
        cycle();

        // Fetch only, memory answers the cycle after mem_req rises.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_3000;
        cycle();
        check("fetch_req", 32'(bus.mem_req), 32'h1);
        check("fetch_we", 32'(bus.mem_we), 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h3408_0005;
        cycle();
        check("fetch_ready", 32'(bus.if_ready), 32'h1);
        check("fetch_rdata", bus.if_rdata, 32'h3408_0005);
        bus.if_req = 1'b0; bus.mem_ack = 1'b0;
        cycle();
        check("fetch_pulse_once", 32'(bus.if_ready), 32'h0);

        // Store with a three-cycle memory.
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_0010; bus.dm_wdata = 32'hDEAD_BEEF;
        cycle();
        cycle();
        check("store_addr", bus.mem_addr, 32'h0000_0010);
        cycle();
        check("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("store_req", 32'(bus.mem_req), 32'h1);
        bus.mem_ack = 1'b1;
        cycle();
        check("store_ready", 32'(bus.dm_ready), 32'h1);
        check("store_rdata", bus.dm_rdata, 32'h0);
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.mem_ack = 1'b0;
        cycle();

        // Simultaneous fetch and load: data first, fetch granted in the dm_ready cycle.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_3004;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0020;
        cycle();
        check("sim_dm_first", bus.mem_addr, 32'h0000_0020);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0007;
        cycle();
        check("sim_dm_ready", 32'(bus.dm_ready), 32'h1);
        check("sim_dm_rdata", bus.dm_rdata, 32'h0000_0007);
        bus.dm_req = 1'b0; bus.mem_ack = 1'b0;
        cycle();
        check("sim_if_grant", bus.mem_addr, 32'h0000_3004);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        cycle();
        check("sim_if_ready", 32'(bus.if_ready), 32'h1);
        check("sim_if_rdata", bus.if_rdata, 32'h0BAD_F00D);
        bus.if_req = 1'b0; bus.mem_ack = 1'b0;
        cycle();

        // Reset during DM_BUSY with the ack arriving at the same edge.
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0020;
        cycle();
        check("rstmid_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0055;
        cycle();
        check("rstmid_no_ready", 32'(bus.dm_ready), 32'h0);
        check("rstmid_rdata", bus.dm_rdata, 32'h0);
        rst = 1'b0; bus.dm_req = 1'b0; bus.mem_ack = 1'b0;
        cycle();

        // Spurious ack while idle.
        bus.mem_ack = 1'b1;
        cycle();
        check("idle_ack_busy", 32'(bus.busy), 32'h0);
        bus.mem_ack = 1'b0;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
